spatial_accum_sequencer: RTL
============================

# spatial_accum_sequencer

Controller that sequences one sample's worth of channels through `spatial_accumulator`. It issues channel read addresses to the feature buffer and projection item memory, and generates the accumulator's per-cycle control strobes (`Enable_SI`, `FirstHypervector_SI`, `store_second`, `xor_final`) aligned to the one-cycle memory read latency. It then holds the resulting spatial hypervector with a valid/ready handshake until the temporal stage consumes it. It sits between the sample-arrival logic and the spatial encoder datapath.

## Interface
- `MOD0_CHANNELS`, default 32, channel count of modality 0 (≥2).
- `MOD1_CHANNELS`, default 77, channel count of modality 1 (≥2).
- `MOD2_CHANNELS`, default 108, channel count of modality 2 (≥2).
- `ADDR_WIDTH`, default 8, global channel address width; must satisfy 2^ADDR_WIDTH ≥ total channels (217).
- `Clk_CI`  in  1  single clock; all state on rising edge.
- `Reset_RI`  in  1  synchronous, active-high reset.
- `Start_SI`  in  1  new sample ready in feature buffer; sampled only in IDLE.
- `Idle_SO`  out  1  high in IDLE (Start is accepted).
- `ChanAddr_DO`  out  ADDR_WIDTH  global channel index to feature buffer and item memory.
- `ChanRdEn_SO`  out  1  read strobe for `ChanAddr_DO`; data returns next cycle.
- `AccEnable_SO`  out  1  drives accumulator `Enable_SI`.
- `AccFirst_SO`  out  1  drives `FirstHypervector_SI`.
- `AccStoreSecond_SO`  out  1  drives `store_second`.
- `AccXorFinal_SO`  out  1  drives `xor_final`.
- `HvValid_SO`  out  1  accumulator `HypervectorOut_DO` is final.
- `HvReady_SI`  in  1  downstream accepts the hypervector.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: `Idle_SO`=1. On `Start_SI`=1, go to FETCH and clear the global counter g, the modality counter m, and the local counter l.
- FETCH: `ChanRdEn_SO`=1, `ChanAddr_DO`=g. Each cycle g++ and l++. When l = count(m)−1, set l=0 and m++. After issuing g = total−1, go to DRAIN.
- Control stage: a one-cycle pipeline register captures (read issued, g==0, l==1, l==count(m)−1). Its outputs drive the Acc* strobes. The strobes therefore coincide with the cycle in which that channel's `FeatureIn_DI`/projM data is present at the accumulator.
  - `AccEnable_SO` = delayed read strobe.
  - `AccFirst_SO` = delayed (g==0).
  - `AccStoreSecond_SO` = delayed (l==1).
  - `AccXorFinal_SO` = delayed (l==last of modality).
- A 2-channel modality asserts StoreSecond and XorFinal on the same channel; this is legal.
- DRAIN: no read is issued. The pipeline delivers the last channel's strobes. Go to DONE.
- DONE: `HvValid_SO`=1. All Acc* outputs are 0, so the accumulator holds. On `HvReady_SI`=1, go to IDLE.
- `Start_SI` is ignored outside IDLE. It is not queued.
- Counters use no wrap-around arithmetic; g never exceeds total−1.

## Timing
- Reset (and reset mid-operation): FSM→IDLE, all counters 0, pipeline register cleared. Output values after reset:
  - `Idle_SO`=1
  - `ChanAddr_DO`=0
  - `ChanRdEn_SO`=0
  - all `Acc*`=0
  - `HvValid_SO`=0
- An aborted sample is not completed. The next accepted Start restarts cleanly, because `AccFirst_SO` overwrites the accumulator.
- With Start accepted in cycle c0:
  - Reads are issued in c1…c217 for addresses 0…216.
  - `AccEnable_SO` is high in c2…c218.
  - `AccFirst_SO` is high in c2 only.
  - `HvValid_SO` rises in c219. Latency is total+2 cycles.
- Valid/ready: Valid stays high until the cycle in which Ready=1. Transfer occurs in that cycle. IDLE follows on the next cycle, so minimum Start spacing is total+3 cycles.
- Ready=1 while Valid=0 has no effect.
- Simultaneous Reset with any input: reset wins.

## Structure
- `const.vh` holds:
  - the modality channel counts
  - total channel count
  - `ADDR_WIDTH`
  - FSM state encodings (2-bit localparams shared with any debug/monitor logic).
- One sub-module: `channel_index_counter`. It owns g/m/l, takes the clear and advance inputs, and outputs g plus the first/second/last/done flags.
- The FSM and control pipeline register live in the top module.

## Test plan
- Reset then idle, then Start pulse with defaults:
  - `ChanAddr_DO` steps 0…216 in c1…c217.
  - `AccEnable_SO` is high exactly 217 cycles (c2…c218).
  - `HvValid_SO` goes high at c219.
- Modality flags, with defaults:
  - `AccStoreSecond_SO` is high on enables for channels 1, 33, 110.
  - `AccXorFinal_SO` is high on enables for channels 31, 108, 216.
  - `AccFirst_SO` is high only for channel 0.
- Back-pressure: hold `HvReady_SI`=0 for 10 cycles after Valid. Required:
  - Valid stays high.
  - All Acc* stay 0.
  - Start pulses are ignored.
  - Ready=1 leads to IDLE next cycle.
- Reset mid-FETCH at address 50:
  - Next cycle all outputs are at reset values.
  - A new Start gives a full 217-channel sequence with `AccFirst_SO` on channel 0.
- Parameter corner `MOD0_CHANNELS`=2:
  - Channel 1 asserts StoreSecond and XorFinal together.
  - Modality 1 starts at address 2.

Source files
------------

// File: rtl/spatial_accum_sequencer_pkg.sv
// Shared constants, state encodings and control bundle for the
// spatial accumulator sequencer.
package spatial_accum_sequencer_pkg;

    localparam int MOD0_CH_DEF    = 32;
    localparam int MOD1_CH_DEF    = 77;
    localparam int MOD2_CH_DEF    = 108;
    localparam int ADDR_WIDTH_DEF = 8;

    // 2-bit encodings kept as plain localparams so monitors can decode them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;

    typedef struct packed {
        logic en;
        logic first;
        logic second;
        logic last;
    } acc_ctrl_t;

    function automatic int total_channels(input int a, input int b, input int c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/spatial_accum_sequencer_channel_index_counter.sv
// Global / modality / local channel counters with position flags
// for the channel currently being issued.
module channel_index_counter
    import spatial_accum_sequencer_pkg::*;
#(
    parameter int M0 = MOD0_CH_DEF,
    parameter int M1 = MOD1_CH_DEF,
    parameter int M2 = MOD2_CH_DEF,
    parameter int AW = ADDR_WIDTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [AW-1:0] o_g,
    output logic          o_first,
    output logic          o_second,
    output logic          o_last,
    output logic          o_done
);

    localparam int TOTAL = total_channels(M0, M1, M2);

    logic [AW-1:0] r_g;
    logic [AW-1:0] r_l;
    logic [1:0]    r_m;
    logic [AW-1:0] w_last_idx;

    always_comb begin
        w_last_idx = AW'(M2 - 1);
        unique case (r_m)
            2'd0:    w_last_idx = AW'(M0 - 1);
            2'd1:    w_last_idx = AW'(M1 - 1);
            default: w_last_idx = AW'(M2 - 1);
        endcase
    end

    assign o_g      = r_g;
    assign o_first  = (r_g == '0);
    assign o_second = (r_l == AW'(1));
    assign o_last   = (r_l == w_last_idx);
    assign o_done   = (r_g == AW'(TOTAL - 1));

    // Counting stops at the final channel, so m never leaves 0..2
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_g <= '0;
            r_l <= '0;
            r_m <= '0;
        end else if (i_advance && !o_done) begin
            r_g <= r_g + AW'(1);
            if (o_last) begin
                r_l <= '0;
                r_m <= r_m + 2'd1;
            end else begin
                r_l <= r_l + AW'(1);
            end
        end
    end

endmodule

// File: rtl/spatial_accum_sequencer.sv
// Sequences one sample's channels through the spatial accumulator and
// holds the result under a valid/ready handshake.
module spatial_accum_sequencer
    import spatial_accum_sequencer_pkg::*;
#(
    parameter int MOD0_CHANNELS = MOD0_CH_DEF,
    parameter int MOD1_CHANNELS = MOD1_CH_DEF,
    parameter int MOD2_CHANNELS = MOD2_CH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    input  logic                  Start_SI,
    output logic                  Idle_SO,
    output logic [ADDR_WIDTH-1:0] ChanAddr_DO,
    output logic                  ChanRdEn_SO,
    output logic                  AccEnable_SO,
    output logic                  AccFirst_SO,
    output logic                  AccStoreSecond_SO,
    output logic                  AccXorFinal_SO,
    output logic                  HvValid_SO,
    input  logic                  HvReady_SI
);

    state_t    r_state;
    state_t    w_state_nxt;
    acc_ctrl_t r_ctrl;
    acc_ctrl_t w_ctrl_nxt;

    logic                  w_clear;
    logic                  w_advance;
    logic                  w_rden;
    logic                  w_idle;
    logic                  w_valid;
    logic [ADDR_WIDTH-1:0] w_g;
    logic                  w_first;
    logic                  w_second;
    logic                  w_last;
    logic                  w_done;

    channel_index_counter #(
        .M0 (MOD0_CHANNELS),
        .M1 (MOD1_CHANNELS),
        .M2 (MOD2_CHANNELS),
        .AW (ADDR_WIDTH)
    ) u_cnt (
        .i_clk     (Clk_CI),
        .i_rst     (Reset_RI),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_g       (w_g),
        .o_first   (w_first),
        .o_second  (w_second),
        .o_last    (w_last),
        .o_done    (w_done)
    );

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    // Counters are held at zero while idle, so a new sample always starts at channel 0
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_rden      = 1'b0;
        w_idle      = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_idle  = 1'b1;
                w_clear = 1'b1;
                if (Start_SI) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_rden    = 1'b1;
                w_advance = 1'b1;
                if (w_done) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (HvReady_SI) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ctrl_nxt        = '0;
        w_ctrl_nxt.en     = w_rden;
        w_ctrl_nxt.first  = w_rden & w_first;
        w_ctrl_nxt.second = w_rden & w_second;
        w_ctrl_nxt.last   = w_rden & w_last;
    end

    assign Idle_SO           = w_idle;
    assign ChanAddr_DO       = w_g;
    assign ChanRdEn_SO       = w_rden;
    assign AccEnable_SO      = r_ctrl.en;
    assign AccFirst_SO       = r_ctrl.first;
    assign AccStoreSecond_SO = r_ctrl.second;
    assign AccXorFinal_SO    = r_ctrl.last;
    assign HvValid_SO        = w_valid;

endmodule
